l2_cache: RTL and testbench
===========================

// Module: l2_cache
// PURPOSE
//  Unified direct-mapped write-back L2 behind the L1 caches. Responder on the L1-facing
//  line interface (128-bit lines, 28-bit line address, level request + one-cycle ready);
//  initiator toward main memory on an identical lower interface. Full-line L1 writes
//  allocate with no fill. Reads fill from memory after any dirty victim write-back.
// PARAMETERS
//  SET_BITS   6    index width; sets = 2**SET_BITS, tag width = 28-SET_BITS
//  LINE_W     128  line width in bits, identical on both interfaces
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous reset, active-low
//  l1_read    in   1    L1 line read request, held until l1_ready is seen
//  l1_write   in   1    L1 full-line write (victim write-back), held until l1_ready
//  l1_addr    in   28   line address; index=[SET_BITS-1:0], tag=[27:SET_BITS]
//  l1_wdata   in   128  write line
//  l1_rdata   out  128  read line, valid while l1_ready=1
//  l1_ready   out  1    one-cycle completion pulse
//  mem_read   out  1    memory line read, held until mem_ready
//  mem_write  out  1    memory line write, held until mem_ready
//  mem_addr   out  28   memory line address
//  mem_wdata  out  128  memory write line
//  mem_rdata  in   128  memory read line, valid with mem_ready
//  mem_ready  in   1    memory completion, sampled on the same edge as the request
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every valid and dirty bit=0; l1_ready=0, l1_rdata=0,
//   mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. Takes effect immediately, even mid-transfer.
//   The in-flight transaction is dropped. Tag and data arrays need no reset.
//  Request latch: in IDLE, l1_read^l1_write=1 latches op/addr/wdata. Read and write both high,
//   or both low, is ignored and the FSM stays in IDLE.
//  FSM:
//   IDLE   -> LOOKUP on an accepted request
//   LOOKUP  hit = valid[idx] && tag[idx]==ltag
//           read hit            -> RESP; l1_rdata<=line
//           write hit           -> RESP; line<=wdata, dirty=1
//           miss, victim dirty  -> WB
//           miss, clean, read   -> FILL
//           miss, clean, write  -> RESP; install wdata, valid=1, dirty=1, tag=ltag
//   WB     mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx] until mem_ready;
//          on mem_ready: dirty[idx]=0; read -> FILL; write -> RESP and install as above
//   FILL   mem_read=1, mem_addr=latched addr until mem_ready; on mem_ready: data=mem_rdata,
//          valid=1, dirty=0, tag=ltag, l1_rdata<=mem_rdata -> RESP
//   RESP   l1_ready=1 for exactly one cycle -> IDLE; L1 inputs are ignored in RESP
//  mem_read and mem_write are never high together; both are 0 outside WB/FILL. The mem_addr and
//   mem_wdata values are 0 whenever no memory request is active.
//  Latency (request first high at cycle t):
//   hit or clean write miss      -> l1_ready at t+2
//   read miss                    -> memory read issued at t+2
//   L1 keeps its request high one cycle after the pulse; RESP->IDLE absorbs it
//  Back-to-back: a new request present in the cycle after l1_ready is accepted in IDLE.
//   It is never merged with or dropped in favour of the previous request.
//  l1_rdata holds its last value between pulses. It is unchanged by writes.
// TESTING
//  1 rst; read 0x0000010; mem_ready 4 cycles after mem_read, rdata=128'hA5..A5
//    -> exactly one l1_ready pulse with l1_rdata=A5..A5. Reread -> ready at t+2, no mem traffic.
//  2 write 0x0000010 data=128'h1 (hit) -> ready at t+2, no mem traffic. Then read 0x0000050:
//    mem_write addr=0x0000010 data=128'h1 first, then mem_read addr=0x0000050, then l1_ready.
//  3 rst; write 0x0000020 data=128'hBEEF (clean miss) -> ready at t+2, no mem traffic.
//    Read 0x0000020 -> 128'hBEEF with no mem traffic.
//  4 L1 holds the request one cycle past l1_ready, then issues read 0x0000030 next cycle
//    -> first request served once; second accepted, one pulse each.
//  5 rst_n low during FILL with mem_read=1 -> all outputs 0 same cycle. After release,
//    read the same address -> miss, new mem_read.
//  6 l1_read=l1_write=1 for 5 cycles -> no l1_ready and no mem traffic; state stays IDLE.

Source files
------------

// File: rtl/l2_cache.sv
// l2_cache
// Unified direct-mapped write-back L2 cache sitting between the L1 caches and
// main memory. A full-line L1 write allocates without a fill. A read miss fills
// from memory, and a dirty victim is written back before that fill.
//
// Ports
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   l1_read / l1_write    L1 request, level, held until l1_ready
//   l1_addr, l1_wdata     line address (index in low bits) and write line
//   l1_rdata, l1_ready    read line and one-cycle completion pulse
//   mem_read / mem_write  memory request, held until mem_ready
//   mem_addr, mem_wdata   memory line address and write line (0 when idle)
//   mem_rdata, mem_ready  memory read line and completion
module l2_cache #(
  parameter int SET_BITS = 6,
  parameter int LINE_W   = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [27:0]       l1_addr,
  input  logic [LINE_W-1:0] l1_wdata,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [27:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int SETS  = 2 ** SET_BITS;
  localparam int TAG_W = 28 - SET_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_RESP
  } state_e;

  state_e              state_q;
  logic                op_write_q;
  logic [27:0]         addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;

  logic [TAG_W-1:0]    tag_mem  [SETS];
  logic [LINE_W-1:0]   data_mem [SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    ltag;
  logic                hit;
  logic                victim_dirty;
  logic                arr_we;
  logic [LINE_W-1:0]   arr_wdata;

  assign idx          = addr_q[SET_BITS-1:0];
  assign ltag         = addr_q[27:SET_BITS];
  assign hit          = valid_q[idx] && (tag_mem[idx] == ltag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  // Tag/data array write port. Every install writes the latched tag, so a
  // write hit simply rewrites the tag it already holds.
  always_comb begin
    arr_we    = 1'b0;
    arr_wdata = wdata_q;
    case (state_q)
      S_LOOKUP: if (op_write_q && (hit || !victim_dirty)) arr_we = 1'b1;
      S_WB:     if (mem_ready && op_write_q) arr_we = 1'b1;
      S_FILL: begin
        if (mem_ready) begin
          arr_we    = 1'b1;
          arr_wdata = mem_rdata;
        end
      end
      default: arr_we = 1'b0;
    endcase
  end

  // Tag and data storage carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[idx]  <= ltag;
      data_mem[idx] <= arr_wdata;
    end
  end

  // Controller FSM with registered L1 and memory outputs. The memory address
  // and write data are returned to 0 whenever a memory request completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      l1_ready   <= 1'b0;
      l1_rdata   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      l1_ready <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (l1_read ^ l1_write) begin
            op_write_q <= l1_write;
            addr_q     <= l1_addr;
            wdata_q    <= l1_wdata;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (op_write_q) dirty_q[idx] <= 1'b1;
            else            l1_rdata     <= data_mem[idx];
            l1_ready <= 1'b1;
            state_q  <= S_RESP;
          end else if (victim_dirty) begin
            mem_write <= 1'b1;
            mem_addr  <= {tag_mem[idx], idx};
            mem_wdata <= data_mem[idx];
            state_q   <= S_WB;
          end else if (!op_write_q) begin
            mem_read <= 1'b1;
            mem_addr <= addr_q;
            state_q  <= S_FILL;
          end else begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b1;
            l1_ready     <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            mem_wdata <= '0;
            if (op_write_q) begin
              // Write miss over a dirty victim: install the L1 line, still dirty.
              mem_addr     <= '0;
              dirty_q[idx] <= 1'b1;
              l1_ready     <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              dirty_q[idx] <= 1'b0;
              mem_read     <= 1'b1;
              mem_addr     <= addr_q;
              state_q      <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            l1_rdata     <= mem_rdata;
            l1_ready     <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache
// Drives l2_cache with directed scenarios followed by randomized L1 traffic,
// acts as main memory, and compares every L1 response and memory transfer
// against a set-level model of the cache and an architectural line store.
module tb_l2_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         l1_read = 1'b0;
  logic         l1_write = 1'b0;
  logic [27:0]  l1_addr = '0;
  logic [127:0] l1_wdata = '0;
  logic [127:0] l1_rdata;
  logic         l1_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int check_count = 0;
  int error_count = 0;

  // Model state: per-set valid/dirty/tag, DRAM contents, and the latest
  // architectural value of every line the L1 has written since reset.
  bit           m_valid [64];
  bit           m_dirty [64];
  logic [21:0]  m_tag   [64];
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] shadow    [logic [27:0]];
  logic [127:0] last_rdata = '0;

  l2_cache #(.SET_BITS(6), .LINE_W(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l1_read   (l1_read),
    .l1_write  (l1_write),
    .l1_addr   (l1_addr),
    .l1_wdata  (l1_wdata),
    .l1_rdata  (l1_rdata),
    .l1_ready  (l1_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Hard stop in case a scenario loop itself goes wrong.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] defaultLine(input logic [27:0] a);
    return {a, 4'h3, ~a, 4'hC, a ^ 28'h5A5A5A5, 4'h9, 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [127:0] memGet(input logic [27:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return defaultLine(a);
  endfunction

  function automatic logic [127:0] shadowGet(input logic [27:0] a);
    if (shadow.exists(a)) return shadow[a];
    return memGet(a);
  endfunction

  // Asserts reset wherever the run currently is, checks that every output
  // clears without waiting for a clock, then releases on the next falling edge.
  task automatic doReset(input string tag);
    rst_n     = 1'b0;
    l1_read   = 1'b0;
    l1_write  = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput({tag, "_ctrl"}, {l1_ready, mem_read, mem_write, mem_addr}, '0);
    checkOutput({tag, "_rdata"}, l1_rdata, '0);
    checkOutput({tag, "_wdata"}, mem_wdata, '0);
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    shadow.delete();
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one L1 request at a falling edge, services memory with the given
  // latency, checks traffic and response, and holds the request through the
  // pulse cycle before dropping it.
  task automatic applyStimulus(input bit is_write, input logic [27:0] addr,
                               input logic [127:0] wdata, input int lat);
    logic [5:0]   idx;
    logic [21:0]  tg;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    logic [127:0] exp_read;
    bit hit, exp_wb, exp_fill, got, wb_seen, fill_seen, active;
    int cyc, wait_cnt;

    idx      = addr[5:0];
    tg       = addr[27:6];
    hit      = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb   = !hit && m_valid[idx] && m_dirty[idx];
    exp_fill = !hit && !is_write;
    wb_addr  = {m_tag[idx], idx};
    wb_data  = shadowGet(wb_addr);
    exp_read = shadowGet(addr);

    l1_read  = !is_write;
    l1_write = is_write;
    l1_addr  = addr;
    l1_wdata = wdata;

    cyc = 0; wait_cnt = 0;
    got = 0; wb_seen = 0; fill_seen = 0; active = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      if (l1_ready) begin
        got = 1;
      end else if (mem_read || mem_write) begin
        if (!active) begin
          active   = 1;
          wait_cnt = 0;
          checkOutput("mem_exclusive", {1'b0, mem_read & mem_write}, '0);
          if (mem_write) begin
            checkOutput("wb_expected", 1'b1, exp_wb && !wb_seen && !fill_seen);
            checkOutput("wb_addr", mem_addr, wb_addr);
            checkOutput("wb_data", mem_wdata, wb_data);
            wb_seen = 1;
          end else begin
            checkOutput("fill_expected", 1'b1, exp_fill && !fill_seen && (wb_seen == exp_wb));
            checkOutput("fill_addr", mem_addr, addr);
            if (!exp_wb) checkOutput("fill_latency", cyc, 2);
            fill_seen = 1;
          end
        end
        if (wait_cnt == lat) begin
          if (mem_write) mem_store[mem_addr] = mem_wdata;
          else           mem_rdata = memGet(mem_addr);
          mem_ready = 1'b1;
          active    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        checkOutput("bus_idle", mem_wdata | 128'(mem_addr), '0);
      end
    end

    checkOutput("ready_seen", got, 1'b1);
    if (got) begin
      if (hit || (is_write && !exp_wb)) checkOutput("ready_latency", cyc, 2);
      checkOutput("wb_done", wb_seen, exp_wb);
      checkOutput("fill_done", fill_seen, exp_fill);
      if (!is_write) checkOutput("read_data", l1_rdata, exp_read);
      else           checkOutput("rdata_hold", l1_rdata, last_rdata);
    end

    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("single_pulse", l1_ready, 1'b0);
    l1_read  = 1'b0;
    l1_write = 1'b0;

    if (exp_wb) m_dirty[idx] = 1'b0;
    if (is_write) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b1;
      shadow[addr] = wdata;
    end else if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (!is_write) last_rdata = exp_read;
  endtask

  initial begin
    int cyc;
    logic [27:0]  raddr;
    logic [127:0] rdata;

    mem_store[28'h0000010] = {16{8'hA5}};
    #2;
    $display("[TB] reset and read fill with writeback ordering");
    doReset("rst_initial");
    applyStimulus(1'b0, 28'h0000010, '0, 4);
    checkOutput("t1_a5", l1_rdata, {16{8'hA5}});
    applyStimulus(1'b0, 28'h0000010, '0, 0);
    applyStimulus(1'b1, 28'h0000010, 128'h1, 0);
    applyStimulus(1'b0, 28'h0000050, '0, 2);
    checkOutput("t2_mem_line", mem_store[28'h0000010], 128'h1);

    $display("[TB] clean write miss then read");
    doReset("rst_t3");
    applyStimulus(1'b1, 28'h0000020, 128'hBEEF, 0);
    applyStimulus(1'b0, 28'h0000020, '0, 0);
    checkOutput("t3_beef", l1_rdata, 128'hBEEF);

    $display("[TB] back-to-back requests");
    applyStimulus(1'b0, 28'h0000020, '0, 0);
    applyStimulus(1'b0, 28'h0000030, '0, 1);

    $display("[TB] reset during fill");
    l1_read  = 1'b1;
    l1_write = 1'b0;
    l1_addr  = 28'h0000440;
    cyc = 0;
    while (!mem_read && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t5_fill_started", mem_read, 1'b1);
    #2;
    doReset("rst_midfill");
    applyStimulus(1'b0, 28'h0000440, '0, 3);

    $display("[TB] conflicting read and write");
    l1_read  = 1'b1;
    l1_write = 1'b1;
    l1_addr  = 28'h0000440;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t6_no_ready", l1_ready, 1'b0);
      checkOutput("t6_no_mem", {mem_read, mem_write}, '0);
    end
    l1_read  = 1'b0;
    l1_write = 1'b0;
    applyStimulus(1'b0, 28'h0000440, '0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 200; n++) begin
      raddr = {20'h0, 2'($urandom_range(0, 3)), 4'h0, 2'($urandom_range(0, 3))};
      rdata = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), raddr, rdata, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
